// File: rtl/axi_w_buffer.sv
// Elastic FIFO for the AXI W channel with a complete-burst counter for store-and-forward.
// Define AXI_W_BUFFER_FALLTHROUGH_EN to let a beat bypass an empty buffer combinationally.
module axi_w_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 8,
  parameter int PTR_WIDTH    = $clog2(BUFFER_DEPTH),
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH)+1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [STRB_WIDTH-1:0] slave_strb_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [STRB_WIDTH-1:0] master_strb_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CNT_WIDTH-1:0]  level_o,
  output logic [CNT_WIDTH-1:0]  burst_cnt_o,
  output logic                  burst_avail_o
);

  typedef struct packed {
    logic [USER_WIDTH-1:0] user;
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  beat_t                mem_q [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] level_q, level_d, burst_cnt_q, burst_cnt_d;

  beat_t in_beat, head_beat, out_beat;
  logic  full, empty, push, pop;
  logic  unused_test_en;

  assign unused_test_en = test_en_i;

  assign in_beat   = '{user: slave_user_i, strb: slave_strb_i, data: slave_data_i, last: slave_last_i};
  assign head_beat = mem_q[rd_ptr_q];
  assign full      = (level_q == CNT_WIDTH'(BUFFER_DEPTH));
  assign empty     = (level_q == '0);

  // Ready ignores master_ready_i so there is no ready-to-ready path through the buffer.
  assign slave_ready_o = !rst_i && !full;
  assign pop           = !empty && master_ready_i;

`ifdef AXI_W_BUFFER_FALLTHROUGH_EN
  logic bypass;
  assign bypass         = empty && slave_valid_i && master_ready_i && !rst_i;
  assign master_valid_o = !empty || (slave_valid_i && !rst_i);
  assign out_beat       = empty ? in_beat : head_beat;
  assign push           = slave_valid_i && slave_ready_o && !bypass;
`else
  assign master_valid_o = !empty;
  assign out_beat       = head_beat;
  assign push           = slave_valid_i && slave_ready_o;
`endif

  assign master_data_o = out_beat.data;
  assign master_strb_o = out_beat.strb;
  assign master_user_o = out_beat.user;
  assign master_last_o = out_beat.last;
  assign level_o       = level_q;
  assign burst_cnt_o   = burst_cnt_q;
  assign burst_avail_o = (burst_cnt_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    burst_cnt_d = burst_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_WIDTH'(1);
      2'b01:   level_d = level_q - CNT_WIDTH'(1);
      default: level_d = level_q;
    endcase
    // Burst decrement keys off the stored head; a bypassed beat never touched the count.
    case ({push && slave_last_i, pop && head_beat.last})
      2'b10:   burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
      2'b01:   burst_cnt_d = burst_cnt_q - CNT_WIDTH'(1);
      default: burst_cnt_d = burst_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_beat;
  end

endmodule
